// File: rtl/xgmii_tx_arbiter_if.sv
// Source-side bundle for xgmii_tx_arbiter: per-source ready, pop strobe and FWFT head beat.
// Pure wiring, adds no latency.
// Pull-style flow: sources only present beats, the arbiter pops one beat per src_rd_en pulse.
interface xgmii_tx_arbiter_if #(
  parameter int NUM_SRC = 3
);
  logic [NUM_SRC-1:0]    src_rdy;
  logic [NUM_SRC-1:0]    src_rd_en;
  logic [64*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]    src_last;
  logic [3*NUM_SRC-1:0]  src_bytes;

  modport master (
    output src_rdy,
    output src_data,
    output src_last,
    output src_bytes,
    input  src_rd_en
  );

  modport slave (
    input  src_rdy,
    input  src_data,
    input  src_last,
    input  src_bytes,
    output src_rd_en
  );
endinterface

// File: rtl/xgmii_tx_arbiter.sv
// Frame-level round-robin arbiter driving one XGMII 64-bit TX port from NUM_SRC frame queues.
// Ready in IDLE -> start beat next cycle; a popped head beat appears on xgmii one cycle after its pop.
// No backpressure toward the MAC; sources must hold a whole frame when ready, pops run unstalled.
module xgmii_tx_arbiter #(
  parameter int NUM_SRC   = 3,
  parameter int IFG_BEATS = 2
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  xgmii_tx_arbiter_if.slave  src,
  output logic [63:0]        xgmii_txd,
  output logic [7:0]         xgmii_txc,
  output logic [NUM_SRC-1:0] grant,
  output logic               busy
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int SUM_W = PTR_W + 1;
  localparam int CNT_W = $clog2(IFG_BEATS + 1);

  typedef struct packed {
    logic [63:0] txd;
    logic [7:0]  txc;
  } beat_t;

  localparam beat_t IDLE_BEAT  = {64'h0707070707070707, 8'hff};
  localparam beat_t START_BEAT = {64'hd5555555555555fb, 8'h01};
  localparam beat_t TERM_BEAT  = {64'h07070707070707fd, 8'hff};

  typedef enum logic [1:0] {IDLE, DATA, TERM, IFG} state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     gidx_q, gidx_d;
  logic [NUM_SRC-1:0]   grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic [CNT_W-1:0]     ifg_q, ifg_d;
  beat_t                out_q, out_d;

  logic [2*NUM_SRC-1:0] rdy_dbl;
  logic [NUM_SRC-1:0]   rdy_rot;
  logic [SUM_W-1:0]     pick_sum;
  logic [PTR_W-1:0]     pick_idx;
  logic [PTR_W-1:0]     ptr_next;
  logic                 pick_vld;

  logic [63:0]          head_dat;
  logic                 head_last;
  logic [2:0]           head_bytes;

  // Terminate-bearing beat: lanes below n carry data, lane n is /T/, lanes above are /I/.
  function automatic beat_t term_beat(input logic [63:0] d, input logic [2:0] n);
    beat_t b;
    b = IDLE_BEAT;
    for (int j = 0; j < 8; j++) begin
      if (j < int'(n)) begin
        b.txd[8*j +: 8] = d[8*j +: 8];
        b.txc[j]        = 1'b0;
      end else if (j == int'(n)) begin
        b.txd[8*j +: 8] = 8'hfd;
        b.txc[j]        = 1'b1;
      end
    end
    return b;
  endfunction

  // Round-robin search: rotate ready so ptr sits at bit 0, the lowest set bit wins.
  always_comb begin
    rdy_dbl  = {src.src_rdy, src.src_rdy};
    rdy_rot  = NUM_SRC'(rdy_dbl >> ptr_q);
    pick_vld = 1'b0;
    pick_sum = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (rdy_rot[k]) begin
        pick_vld = 1'b1;
        pick_sum = {1'b0, ptr_q} + SUM_W'(k);
      end
    end
    if (pick_sum >= SUM_W'(NUM_SRC)) begin
      pick_idx = PTR_W'(pick_sum - SUM_W'(NUM_SRC));
    end else begin
      pick_idx = PTR_W'(pick_sum);
    end
    ptr_next = (pick_idx == PTR_W'(NUM_SRC - 1)) ? '0 : pick_idx + PTR_W'(1);
  end

  // Head beat of the granted source.
  always_comb begin
    head_dat   = src.src_data[64*int'(gidx_q) +: 64];
    head_last  = src.src_last[int'(gidx_q)];
    head_bytes = src.src_bytes[3*int'(gidx_q) +: 3];
  end

  // Next-state and next-output logic; a grant from IDLE or an expired IFG overrides the defaults.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    ifg_d   = ifg_q;
    out_d   = IDLE_BEAT;

    case (state_q)
      IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (pick_vld) begin
          state_d = DATA;
          out_d   = START_BEAT;
          gidx_d  = pick_idx;
          grant_d = NUM_SRC'(1) << pick_idx;
          busy_d  = 1'b1;
          ptr_d   = ptr_next;
        end
      end
      DATA: begin
        out_d = {head_dat, 8'h00};
        if (head_last) begin
          if (head_bytes == 3'd0) begin
            state_d = TERM;
          end else begin
            out_d   = term_beat(head_dat, head_bytes);
            state_d = IFG;
            ifg_d   = '0;
          end
        end
      end
      TERM: begin
        out_d   = TERM_BEAT;
        state_d = IFG;
        ifg_d   = '0;
      end
      IFG: begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (ifg_q == CNT_W'(IFG_BEATS)) begin
          if (pick_vld) begin
            state_d = DATA;
            out_d   = START_BEAT;
            gidx_d  = pick_idx;
            grant_d = NUM_SRC'(1) << pick_idx;
            busy_d  = 1'b1;
            ptr_d   = ptr_next;
          end else begin
            state_d = IDLE;
          end
        end else begin
          ifg_d = ifg_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any frame in flight without a terminate.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      ifg_q   <= '0;
      out_q   <= IDLE_BEAT;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      ifg_q   <= ifg_d;
      out_q   <= out_d;
    end
  end

  assign src.src_rd_en = (state_q == DATA) ? grant_q : '0;
  assign xgmii_txd     = out_q.txd;
  assign xgmii_txc     = out_q.txc;
  assign grant         = grant_q;
  assign busy          = busy_q;

endmodule

// File: doc/xgmii_tx_arbiter.md
# xgmii_tx_arbiter

Frame-level round-robin arbiter that shares one XGMII 64-bit transmit port among NUM_SRC ingress frame queues of the l2switch. It sits between the per-ingress forwarding FIFOs and an egress MAC's xgmii_N_txd/xgmii_N_txc. It owns egress framing: start/preamble insertion, data streaming, terminate encoding and minimum inter-frame gap. One instance is used per egress port.

## Interface
Parameters:
- NUM_SRC, 3: number of requesting source queues (≥2).
- IFG_BEATS, 2: exact idle-beat count between a terminate beat and the next start beat under back-to-back load (≥1).

Ports:
- sys_clk  in  1  system clock (156.25 MHz).
- sys_rst  in  1  synchronous, active-high reset.
- src_rdy  in  NUM_SRC  bit i=1: source i holds at least one complete frame.
- src_rd_en  out  NUM_SRC  one-hot pop of source i's head beat.
- src_data  in  64*NUM_SRC  source i's first-word-fall-through head beat, bits [64i+63:64i], lane 0 = [7:0].
- src_last  in  NUM_SRC  head beat is the frame's last.
- src_bytes  in  3*NUM_SRC  valid bytes in the last beat, 1..7; 0 means 8.
- xgmii_txd  out  64  XGMII transmit data, registered.
- xgmii_txc  out  8  XGMII transmit control, registered.
- grant  out  NUM_SRC  one-hot owner of the frame in progress.
- busy  out  1  frame in progress.

## Operation
- States: IDLE, DATA, TERM, IFG.
- Beat encodings:
  - Idle beat: txd=64'h0707070707070707, txc=8'hff.
  - Start beat: txd=64'hd5555555555555fb, txc=8'h01.
  - Data beat: txc=8'h00.
- IDLE:
  - Outputs idle beats.
  - If any src_rdy is set, pick the first ready source searching from pointer ptr upward, mod NUM_SRC.
  - Latch grant, load the start beat into the output register, set ptr=i+1 mod NUM_SRC, and go to DATA.
- DATA:
  - src_rd_en[grant]=1 every cycle, combinationally.
  - The head beat is registered to the output.
  - On a head beat with src_last=1 and n=src_bytes≠0: lanes 0..n-1 carry data, lane n=8'hfd, lanes above n=8'h07, txc bits n..7 set. Go to IFG.
  - On a last beat with src_bytes=0: output a full data beat and go to TERM.
- TERM: output txd=64'h07070707070707fd, txc=8'hff (one cycle), then go to IFG.
- IFG:
  - Output idle beats and count.
  - When the registered output holds the IFG_BEATS-th idle beat, arbitrate exactly as in IDLE. If a source is ready, the next edge loads the start beat; otherwise go to IDLE.
- Round-robin: ptr resets to 0 and advances only on a grant.
- src_rdy changes during DATA are ignored. Sources guarantee the complete frame is present when rdy is asserted, so there are no underrun stalls.
- The number of src_rd_en pulses equals the frame's beat count exactly. No pops occur outside DATA.

## Timing
- Reset values: xgmii_txd=64'h0707070707070707, xgmii_txc=8'hff, src_rd_en=0, grant=0, busy=0, ptr=0, state IDLE.
- Latency:
  - src_rdy seen in IDLE in cycle N → start beat on xgmii in cycle N+1.
  - First src_rd_en in cycle N+1 → that beat on xgmii in cycle N+2.
- grant and busy are valid from the start-beat cycle through the beat containing 8'hfd, inclusive, and are 0 otherwise.
- Single-beat frames are legal: start beat, then the terminate-bearing beat.
- Back-to-back frames: exactly IFG_BEATS idle beats between the 8'hfd beat and the next start beat. Default IFG_BEATS=2 guarantees ≥12 idle bytes.
- Simultaneous src_rdy: only round-robin order matters. There is no fixed priority beyond ptr.
- sys_rst mid-frame:
  - Next cycle outputs an idle beat with no terminate, and clears grant, busy and ptr.
  - The sources are reset by the same sys_rst.

## Test plan
- Reset: hold sys_rst 2 cycles → txd=64'h0707070707070707, txc=8'hff, src_rd_en=0, grant=0, busy=0.
- Frame from source 0: 8 beats, last src_bytes=4 (60 bytes) → start beat d5555555555555fb/01, then 7 data beats with txc=00, then terminate beat {07,07,07,fd,d[31:0]} with txc=8'hf0. Exactly 8 src_rd_en[0] pulses. Idle after.
- Frame from source 1: 8 beats, last src_bytes=0 → 8 data beats with txc=00, then 64'h07070707070707fd/ff, then idle.
- All three sources ready continuously, one frame each, repeated → grant order 0,1,2,0. Exactly 2 idle beats between each fd-bearing beat and the next start beat.
- Single-beat frame on source 2 with src_bytes=1 → start beat, then a beat with lane0=data, lane1=fd, lanes2-7=07, txc=8'hfe.
- sys_rst asserted during DATA of source 1 → idle output the next cycle with grant=0. After release, with sources 0 and 1 ready, source 0 is granted first.
